param_clock_divider: RTL and testbench
======================================

// Module: param_clock_divider
// PURPOSE
//   NUM_CH independent square-wave clock dividers sharing one input clock. Each channel has a
//   divisor that can be changed at run time without glitches. Each channel also gives a
//   one-cycle tick strobe that logic on in_clk can use as a clock enable.
//   Used for display refresh, debounce sampling and UI timing in place of fixed dividers.
// PARAMETERS
//   NUM_CH       4       number of divider channels (1..16)
//   CNT_W        27      width of the half-period counter and of the divisor
//   DEFAULT_HALF 100000  half-period loaded into every channel at reset (in_clk cycles)
//   CH_W         2       channel index width; must be >= clog2(NUM_CH), minimum 1
// PORTS
//   in_clk     in   1           system clock; all logic is on posedge
//   rst        in   1           synchronous reset, active-high
//   en         in   1           global run enable; 0 freezes all counters
//   sync       in   1           phase-align pulse: restarts all channels together
//   cfg_valid  in   1           divisor write request
//   cfg_ready  out  1           write can be accepted this cycle
//   cfg_ch     in   CH_W        target channel of the write
//   cfg_half   in   CNT_W       new half-period; 0 means stop the channel
//   cfg_err    out  1           1-cycle pulse when an accepted write had cfg_ch >= NUM_CH
//   out_clk    out  NUM_CH      divided square waves, bit i = channel i
//   tick       out  NUM_CH      1-cycle pulse, registered in the same cycle out_clk[i] toggles
// BEHAVIOUR
//   Reset (rst=1 at posedge): every cnt=0, out_clk=0, tick=0, cfg_err=0, half=DEFAULT_HALF,
//     pending=0. Reset takes priority over all other inputs, including mid-period and mid-write.
//   Per channel i, per cycle, in priority order:
//     rst > sync > en=0 hold > count.
//   Counting (en=1, half!=0): if cnt==half-1 then cnt<=0, out_clk[i] toggles, tick[i]=1.
//     Otherwise cnt<=cnt+1 and tick[i]=0.
//     Output period = 2*half in_clk cycles, with a 50% duty cycle.
//     half=1 toggles out_clk every cycle (in_clk/2).
//   Stopped (half==0): cnt held at 0, out_clk[i] forced to 0, tick[i]=0.
//   en=0: cnt and out_clk hold their values, tick=0. Writes are still accepted.
//   Handshake: a write is accepted when cfg_valid && cfg_ready.
//     cfg_ready = !pending[cfg_ch] for in-range channels, and 1 for out-of-range channels.
//     cfg_ready is combinational from cfg_ch and the pending flags; it does not depend on cfg_valid.
//     An accepted in-range write stores shadow[i]<=cfg_half and sets pending[i]<=1
//     (visible from the next cycle).
//     An accepted out-of-range write changes no state and sets cfg_err=1 on the next cycle.
//   Applying a pending write (glitch-free): it is applied only at a period boundary, which is
//     one of the following:
//     (a) the terminal-count cycle of that channel;
//     (b) a sync cycle;
//     (c) any cycle in which the channel is stopped (half==0).
//     On apply: half<=shadow, pending<=0, cnt<=0.
//     A write accepted in the same cycle as a boundary is not applied in that cycle; it waits for
//     the next boundary.
//     Applying half=0 forces out_clk[i] to 0 from the next cycle.
//   sync=1 (and rst=0), all channels:
//     cnt<=0, out_clk<=0, tick<=0, pending values applied.
//     This happens even when en=0.
//   Counter arithmetic: compare cnt==half-1 in CNT_W bits.
//     A running counter never wraps past half-1.
//     A counter already >= new half cannot occur, because apply always clears cnt.
// STRUCTURE
//   Shared package/header (clkdiv_defs): CNT_W, DEFAULT_HALF, the channel-index width function,
//     and the HALF_STOP=0 constant.
//   Sub-module clkdiv_channel: one channel (cnt, half, shadow, pending, out_clk, tick), with
//     inputs en, sync, wr, wr_half.
//   Top level: generate loop over NUM_CH, the cfg_ch decode, cfg_ready mux and cfg_err register.
// TESTING
//   1. Reset with DEFAULT_HALF=5 and en=1
//      -> out_clk[0] rises at cycle 5 after reset release, then toggles every 5 cycles;
//         tick high exactly in the toggle cycles.
//   2. Write ch1 half=3 in the middle of a period
//      -> cfg_ready[ch1]=0 until the next terminal count; the old period completes, then
//         period=6 with no runt pulse.
//   3. A write to ch2 arrives in the same cycle as its terminal count
//      -> not applied at that boundary, applied at the following one.
//         A second write to ch2 while pending -> cfg_ready=0 and is not accepted.
//   4. Write half=0 to ch0
//      -> out_clk[0]=0 after the boundary.
//         Then write half=2 -> applied the next cycle; first toggle 2 cycles later.
//   5. Out-of-range write with NUM_CH=3 and cfg_ch=3
//      -> cfg_ready=1, cfg_err pulses for 1 cycle, no channel changes.
//   6. Channels with different counts, sync=1, en=0 for 4 cycles, then rst in the middle of a period
//      -> sync: all out_clk=0 and cnt=0 together.
//      -> en=0: everything holds.
//      -> rst: all restored to reset values in the next cycle.

Source files
------------

// File: rtl/clkdiv_defs.sv
// Shared constants and helpers for the multi-channel clock divider.
// Holds default widths/half-periods, the stop encoding and the channel-index width rule.
package clkdiv_defs;

    localparam int DEF_CNT_W        = 27;
    localparam int DEF_DEFAULT_HALF = 100000;
    localparam int HALF_STOP        = 0;

    // Channel index width: clog2 of the channel count, never below 1.
    function automatic int ch_idx_w(input int num_ch);
        return (num_ch <= 1) ? 1 : $clog2(num_ch);
    endfunction

endpackage

// File: rtl/clkdiv_channel.sv
// One divider channel: half-period counter, square-wave output, tick strobe, shadowed divisor.
// Latency: out_clk/tick registered; a divisor write takes effect at the next period boundary.
// Backpressure: pending is high while a shadowed divisor awaits a boundary; wr must be gated by it.
module clkdiv_channel
    import clkdiv_defs::*;
#(
    parameter int CNT_W        = DEF_CNT_W,
    parameter int DEFAULT_HALF = DEF_DEFAULT_HALF
) (
    input  logic             in_clk,
    input  logic             rst,
    input  logic             en,
    input  logic             sync,
    input  logic             wr,
    input  logic [CNT_W-1:0] wr_half,
    output logic             pending,
    output logic             out_clk,
    output logic             tick
);

    localparam logic [CNT_W-1:0] RST_HALF  = CNT_W'(DEFAULT_HALF);
    localparam logic [CNT_W-1:0] STOP_HALF = CNT_W'(HALF_STOP);

    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] half;
    logic [CNT_W-1:0] shadow;
    logic             stopped;
    logic             terminal;
    logic             apply;

    assign stopped  = (half == STOP_HALF);
    assign terminal = !sync && !stopped && en && (cnt == half - 1'b1);
    // Divisor changes only land where the waveform is already at a clean edge or forced low.
    assign apply    = pending && (sync || stopped || terminal);

    always_ff @(posedge in_clk) begin
        if (rst) begin
            cnt     <= '0;
            half    <= RST_HALF;
            shadow  <= RST_HALF;
            pending <= 1'b0;
            out_clk <= 1'b0;
            tick    <= 1'b0;
        end else begin
            tick <= terminal;
            if (sync || stopped) begin
                cnt     <= '0;
                out_clk <= 1'b0;
            end else if (terminal) begin
                cnt     <= '0;
                out_clk <= ~out_clk;
            end else if (en) begin
                cnt <= cnt + 1'b1;
            end

            if (apply) begin
                half    <= shadow;
                pending <= 1'b0;
                cnt     <= '0;
                if (shadow == STOP_HALF) begin
                    out_clk <= 1'b0;
                end
            end

            // wr is only issued while pending is low, so it never collides with apply.
            if (wr) begin
                shadow  <= wr_half;
                pending <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/param_clock_divider.sv
// NUM_CH glitch-free run-time programmable clock dividers with per-channel tick enables.
// Latency: outputs registered; cfg_err one cycle after an out-of-range write is accepted.
// Backpressure: cfg_ready drops while the addressed channel still holds an unapplied divisor.
module param_clock_divider
    import clkdiv_defs::*;
#(
    parameter int NUM_CH       = 4,
    parameter int CNT_W        = DEF_CNT_W,
    parameter int DEFAULT_HALF = DEF_DEFAULT_HALF,
    parameter int CH_W         = 2
) (
    input  logic              in_clk,
    input  logic              rst,
    input  logic              en,
    input  logic              sync,
    input  logic              cfg_valid,
    output logic              cfg_ready,
    input  logic [CH_W-1:0]   cfg_ch,
    input  logic [CNT_W-1:0]  cfg_half,
    output logic              cfg_err,
    output logic [NUM_CH-1:0] out_clk,
    output logic [NUM_CH-1:0] tick
);

    localparam logic [CH_W:0] NUM_CH_V = NUM_CH[CH_W:0];

    logic [NUM_CH-1:0] pending;
    logic [NUM_CH-1:0] wr;
    logic              in_range;
    logic              sel_pending;
    logic              accept;

    assign in_range = ({1'b0, cfg_ch} < NUM_CH_V);

    always_comb begin
        sel_pending = 1'b0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (cfg_ch == i[CH_W-1:0]) begin
                sel_pending = pending[i];
            end
        end
    end

    // Out-of-range writes are always taken so a bad index can never stall the master.
    assign cfg_ready = in_range ? !sel_pending : 1'b1;
    assign accept    = cfg_valid && cfg_ready;

    always_comb begin
        wr = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            wr[i] = accept && (cfg_ch == i[CH_W-1:0]);
        end
    end

    always_ff @(posedge in_clk) begin
        if (rst) begin
            cfg_err <= 1'b0;
        end else begin
            cfg_err <= accept && !in_range;
        end
    end

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        clkdiv_channel #(
            .CNT_W        (CNT_W),
            .DEFAULT_HALF (DEFAULT_HALF)
        ) u_ch (
            .in_clk  (in_clk),
            .rst     (rst),
            .en      (en),
            .sync    (sync),
            .wr      (wr[g]),
            .wr_half (cfg_half),
            .pending (pending[g]),
            .out_clk (out_clk[g]),
            .tick    (tick[g])
        );
    end

endmodule

// File: tb/tb_param_clock_divider.sv
// Bench for param_clock_divider: directed scenarios then random traffic, all checked
// every cycle against a per-channel behavioural model of the divider rules.
module tb_param_clock_divider;

    localparam int NCH = 3;
    localparam int CW  = 8;
    localparam int DH  = 5;
    localparam int CHW = 2;

    logic            in_clk = 1'b0;
    logic            rst, en, sync, cfg_valid, cfg_ready, cfg_err;
    logic [CHW-1:0]  cfg_ch;
    logic [CW-1:0]   cfg_half;
    logic [NCH-1:0]  out_clk, tick;

    int errors = 0;
    int checks = 0;

    // Reference model: position within the current half-period, active and queued divisors.
    int m_pos[NCH];
    int m_half[NCH];
    int m_next[NCH];
    bit m_queued[NCH];
    bit m_level[NCH];
    bit m_tick[NCH];
    bit m_err;

    param_clock_divider #(
        .NUM_CH       (NCH),
        .CNT_W        (CW),
        .DEFAULT_HALF (DH),
        .CH_W         (CHW)
    ) dut (
        .in_clk    (in_clk),
        .rst       (rst),
        .en        (en),
        .sync      (sync),
        .cfg_valid (cfg_valid),
        .cfg_ready (cfg_ready),
        .cfg_ch    (cfg_ch),
        .cfg_half  (cfg_half),
        .cfg_err   (cfg_err),
        .out_clk   (out_clk),
        .tick      (tick)
    );

    always #5 in_clk = ~in_clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic bit exp_ready(input int ch);
        return (ch >= NCH) ? 1'b1 : !m_queued[ch];
    endfunction

    task automatic model_step(input bit r, input bit e, input bit s, input bit v,
                              input int ch, input int hf);
        bit accepted;
        bit edge_here;
        accepted = v && exp_ready(ch);
        if (r) begin
            for (int i = 0; i < NCH; i++) begin
                m_pos[i] = 0; m_half[i] = DH; m_next[i] = DH;
                m_queued[i] = 0; m_level[i] = 0; m_tick[i] = 0;
            end
            m_err = 0;
            return;
        end
        for (int i = 0; i < NCH; i++) begin
            edge_here = !s && m_half[i] != 0 && e && (m_pos[i] + 1 == m_half[i]);
            m_tick[i] = edge_here;
            if (s || m_half[i] == 0) begin
                m_pos[i] = 0;
                m_level[i] = 0;
            end else if (edge_here) begin
                m_pos[i] = 0;
                m_level[i] = !m_level[i];
            end else if (e) begin
                m_pos[i] = m_pos[i] + 1;
            end
            if (m_queued[i] && (s || m_half[i] == 0 || edge_here)) begin
                m_half[i] = m_next[i];
                m_queued[i] = 0;
                m_pos[i] = 0;
                if (m_half[i] == 0) m_level[i] = 0;
            end
            if (accepted && ch == i) begin
                m_next[i] = hf;
                m_queued[i] = 1;
            end
        end
        m_err = accepted && (ch >= NCH);
    endtask

    // One clock: drive at negedge, check ready, model the edge, check outputs at next negedge.
    task automatic cyc(input bit r, input bit e, input bit s, input bit v,
                       input int ch, input int hf);
        logic [NCH-1:0] eo, et;
        rst = r; en = e; sync = s; cfg_valid = v;
        cfg_ch = ch[CHW-1:0]; cfg_half = hf[CW-1:0];
        #1;
        check("cfg_ready", {31'b0, cfg_ready}, {31'b0, exp_ready(ch)});
        @(posedge in_clk);
        model_step(r, e, s, v, ch, hf);
        @(negedge in_clk);
        for (int i = 0; i < NCH; i++) begin
            eo[i] = m_level[i];
            et[i] = m_tick[i];
        end
        check("out_clk", {29'b0, out_clk}, {29'b0, eo});
        check("tick", {29'b0, tick}, {29'b0, et});
        check("cfg_err", {31'b0, cfg_err}, {31'b0, m_err});
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) cyc(0, 1, 0, 0, 0, 0);
    endtask

    initial begin
        int n, t0, t1, t2, found;
        rst = 1; en = 0; sync = 0; cfg_valid = 0; cfg_ch = '0; cfg_half = '0;
        @(negedge in_clk);

        // Reset values
        cyc(1, 1, 0, 0, 0, 0);
        cyc(1, 1, 0, 0, 0, 0);
        check("rst_out", {29'b0, out_clk}, 32'd0);
        check("rst_tick", {29'b0, tick}, 32'd0);

        // First rise 5 cycles after reset release, then every 5
        found = 0;
        for (n = 1; n <= 20; n++) begin
            cyc(0, 1, 0, 0, 0, 0);
            if (out_clk[0]) begin found = n; break; end
        end
        check("first_rise", found, 5);
        found = 0;
        for (n = 1; n <= 20; n++) begin
            cyc(0, 1, 0, 0, 0, 0);
            if (!out_clk[0]) begin found = n; break; end
        end
        check("half_period0", found, 5);

        // Mid-period write ch1 half=3: old period completes, then half-periods of 3
        idle(2);
        cyc(0, 1, 0, 1, 1, 3);
        t0 = -1; t1 = -1; t2 = -1;
        for (n = 1; n <= 40; n++) begin
            cyc(0, 1, 0, 0, 1, 0);
            if (tick[1]) begin
                if (t0 < 0) t0 = n;
                else if (t1 < 0) t1 = n;
                else begin t2 = n; break; end
            end
        end
        check("ch1_gap_a", t1 - t0, 3);
        check("ch1_gap_b", t2 - t1, 3);

        // Write to ch2 exactly on its terminal count, then a rejected second write
        for (n = 0; n < 20; n++) begin
            if (!m_queued[2] && m_half[2] != 0 && m_pos[2] + 1 == m_half[2]) break;
            cyc(0, 1, 0, 0, 2, 0);
        end
        cyc(0, 1, 0, 1, 2, 2);
        #1 check("ch2_busy", {31'b0, cfg_ready}, 32'd0);
        cyc(0, 1, 0, 1, 2, 4);
        idle(20);

        // Stop ch0, then restart with half=2
        for (n = 0; n < 20 && m_queued[0]; n++) idle(1);
        cyc(0, 1, 0, 1, 0, 0);
        idle(12);
        check("stop_out0", {31'b0, out_clk[0]}, 32'd0);
        for (n = 0; n < 20 && m_queued[0]; n++) idle(1);
        cyc(0, 1, 0, 1, 0, 2);
        found = 0;
        for (n = 1; n <= 10; n++) begin
            cyc(0, 1, 0, 0, 0, 0);
            if (out_clk[0]) begin found = n; break; end
        end
        check("restart_rise", found, 3);

        // Out-of-range write
        cfg_ch = 2'd3;
        #1 check("oor_ready", {31'b0, cfg_ready}, 32'd1);
        cyc(0, 1, 0, 1, 3, 1);
        check("oor_err", {31'b0, cfg_err}, 32'd1);
        idle(1);
        check("oor_err_clr", {31'b0, cfg_err}, 32'd0);

        // sync, freeze, reset mid-period
        idle(3);
        cyc(0, 1, 1, 0, 0, 0);
        check("sync_out", {29'b0, out_clk}, 32'd0);
        for (int k = 0; k < 4; k++) cyc(0, 0, 0, 0, 0, 0);
        idle(3);
        cyc(1, 1, 0, 0, 0, 0);
        check("rst2_out", {29'b0, out_clk}, 32'd0);

        // Random traffic
        for (int k = 0; k < 1500; k++) begin
            cyc(($urandom % 200) == 0, ($urandom % 8) != 0, ($urandom % 60) == 0,
                ($urandom % 3) == 0, int'($urandom % 4), int'($urandom % 5));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
